instr_host: RTL
===============

INSTR_HOST -- requirements
Module: instr_host

Interface
REQ-001 Parameter DEPTH, default 64: expression buffer entries, addressed by the 6-bit Instr_Addr.
REQ-002 Parameter END_CHAR, default 8'h3D ('='): expression terminator byte.
REQ-003 Parameter TIMEOUT, default 4096: maximum cycles in RUN before the block aborts.
REQ-004 Sysclk  in  1: single clock; all state updates on rising edge.
REQ-005 Rst  in  1: reset, asynchronous, active-high.
REQ-006 Char_In  in  8: ASCII expression byte from the host side.
REQ-007 Char_Valid  in  1: Char_In is valid.
REQ-008 Char_Ready  out  1: block accepts Char_In this cycle.
REQ-009 Instr_Addr  in  6: read address from the calculator.
REQ-010 Instr  out  8: byte at Instr_Addr.
REQ-011 En  out  1: calculator enable; 0 holds the calculator in initialisation.
REQ-012 St  out  1: calculator start.
REQ-013 Finish  in  1: calculator done pulse, one cycle wide.
REQ-014 Result  in  16: calculator result, valid while Finish=1.
REQ-015 Res_Valid  out  1: Res_Data is valid.
REQ-016 Res_Data  out  16: captured result.
REQ-017 Res_Ready  in  1: host side accepts Res_Data.
REQ-018 Err  out  1: sticky error flag (overflow or timeout); cleared on the next accepted char in IDLE.

Function
REQ-019 States SHALL be IDLE, LOAD, KICK, RUN, RESULT and CLEAR; the block SHALL enter IDLE out of reset.
REQ-020 Char_Ready SHALL be 1 only in IDLE and LOAD.
REQ-021 A char transfers when Char_Valid=1 and Char_Ready=1.
REQ-022 Each transferred char SHALL be written to buffer[wr_ptr]; wr_ptr then increments.
REQ-023 IDLE SHALL reset wr_ptr to 0.
REQ-024 IDLE, non-END_CHAR transfer: store the char, go to LOAD.
REQ-025 IDLE, END_CHAR transfer (empty expression): drop the char, stay in IDLE.
REQ-026 LOAD, END_CHAR transfer: store it, record length = wr_ptr+1, go to KICK next cycle.
REQ-027 LOAD, transfer at wr_ptr=DEPTH-1 that is not END_CHAR: write END_CHAR instead, set Err=1, go to KICK.
REQ-028 Instr SHALL be a combinational read of Instr_Addr, with zero-cycle latency.
REQ-029 For Instr_Addr >= length, Instr SHALL equal END_CHAR.
REQ-030 En SHALL be 1 in KICK, RUN and RESULT, and 0 in all other states.
REQ-031 St SHALL be 1 for exactly the single KICK cycle.
REQ-032 KICK SHALL go to RUN unconditionally.
REQ-033 RUN, Finish=1: capture Result into Res_Data, go to RESULT.
REQ-034 Finish SHALL be ignored outside RUN.
REQ-035 RUN timeout counter: starts at 0 on entry; at TIMEOUT-1 without Finish, load Res_Data=16'hFFFF, set Err=1, go to RESULT.
REQ-036 If Finish arrives on the timeout cycle, Finish SHALL win.
REQ-037 Res_Valid SHALL be 1 only in RESULT.
REQ-038 Res_Data SHALL be held stable until Res_Valid and Res_Ready are both 1; the block then goes to CLEAR.
REQ-039 CLEAR SHALL last exactly one cycle with En=0, then go to IDLE.

Reset
REQ-040 Rst SHALL force state=IDLE, wr_ptr=0, length=0, Res_Data=0, Err=0, En=0, St=0, Res_Valid=0 and timeout counter=0 immediately, in any state, including mid-RUN.
REQ-041 Buffer contents need not be cleared by reset; length=0 makes every read return END_CHAR.

Structure
REQ-042 Shared package calc_pkg SHALL hold END_CHAR, DEPTH, TIMEOUT defaults and the state encoding.
REQ-043 One sub-module instr_buffer SHALL hold the DEPTH x 8 storage: synchronous write, asynchronous read.

Verification
REQ-044 "3+4=" test:
- stimulus: chars 33,2B,34,3D, then calculator stub Finish with Result=0x0007;
- response: St pulses once; Instr_Addr 0..3 returns 33,2B,34,3D; addr 10 returns 3D; Res_Valid=1, Res_Data=0x0007, Err=0.
REQ-045 Overflow test:
- stimulus: 70 chars 8'h31, no terminator;
- response: 64 accepted; Char_Ready=0 from the 65th; buffer[63]=3D; Err=1; St pulses.
REQ-046 Timeout test:
- stimulus: "1=" with Finish never asserted;
- response: after 4096 RUN cycles, Res_Valid=1, Res_Data=0xFFFF, Err=1.
REQ-047 Backpressure test:
- stimulus: Res_Ready held 0 for 5 cycles after Res_Valid;
- response: Res_Data stable throughout; one cycle with En=0 after acceptance; then Char_Ready=1.
REQ-048 Reset mid-RUN test:
- stimulus: Rst asserted in RUN;
- response: En=0, Res_Valid=0 in the same cycle; addr 0 reads 3D; a later "5=" completes normally.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants, state encoding and helpers for the calculator host
package calc_pkg;

  localparam int               DEPTH_DEF      = 64;
  localparam logic [7:0]       END_CHAR_DEF   = 8'h3D;
  localparam int               TIMEOUT_DEF    = 4096;
  localparam int               ADDR_W         = 6;
  localparam int               CHAR_W         = 8;
  localparam int               RES_W          = 16;
  localparam logic [RES_W-1:0] TIMEOUT_RESULT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_KICK   = 3'd2,
    ST_RUN    = 3'd3,
    ST_RESULT = 3'd4,
    ST_CLEAR  = 3'd5
  } state_t;

  // Expression length once the byte at ptr (the terminator) has been stored.
  function automatic logic [ADDR_W:0] next_len(input logic [ADDR_W-1:0] ptr);
    return {1'b0, ptr} + {{ADDR_W{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/instr_host_if.sv
// rtl/instr_host_if.sv - host/calculator-facing signal bundle of instr_host
interface instr_host_if;
  import calc_pkg::*;

  logic [CHAR_W-1:0] Char_In;
  logic              Char_Valid;
  logic              Char_Ready;
  logic [ADDR_W-1:0] Instr_Addr;
  logic [CHAR_W-1:0] Instr;
  logic              En;
  logic              St;
  logic              Finish;
  logic [RES_W-1:0]  Result;
  logic              Res_Valid;
  logic [RES_W-1:0]  Res_Data;
  logic              Res_Ready;
  logic              Err;

  // Environment side: host byte source, calculator and result sink.
  modport master (
    output Char_In, Char_Valid, Instr_Addr, Finish, Result, Res_Ready,
    input  Char_Ready, Instr, En, St, Res_Valid, Res_Data, Err
  );

  // instr_host side.
  modport slave (
    input  Char_In, Char_Valid, Instr_Addr, Finish, Result, Res_Ready,
    output Char_Ready, Instr, En, St, Res_Valid, Res_Data, Err
  );

endinterface

// File: rtl/instr_buffer.sv
// rtl/instr_buffer.sv - expression byte storage, synchronous write, asynchronous read
module instr_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:DEPTH-1];

  // Contents are left uninitialised; the owner masks reads beyond the valid length.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_host.sv
// rtl/instr_host.sv - loads an ASCII expression, runs the calculator and returns its result
module instr_host
  import calc_pkg::*;
#(
  parameter int         DEPTH    = DEPTH_DEF,
  parameter logic [7:0] END_CHAR = END_CHAR_DEF,
  parameter int         TIMEOUT  = TIMEOUT_DEF
) (
  input logic         Sysclk,
  input logic         Rst,
  instr_host_if.slave bus
);

  localparam int               AW       = ADDR_W;
  localparam int               LW       = AW + 1;
  localparam int               TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW-1:0]    LAST_PTR = AW'(DEPTH - 1);
  localparam logic [LW-1:0]    FULL_LEN = LW'(DEPTH);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     len_q, len_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic              err_q, err_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic              buf_we;
  logic [AW-1:0]     buf_waddr;
  logic [CHAR_W-1:0] buf_wdata;
  logic [CHAR_W-1:0] buf_rdata;

  logic              char_ready;
  logic              en;
  logic              st;
  logic              res_valid;

  instr_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (CHAR_W)
  ) u_buffer (
    .clk_i   (Sysclk),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (buf_wdata),
    .raddr_i (bus.Instr_Addr),
    .rdata_o (buf_rdata)
  );

  // State and datapath registers; reset clears everything except buffer contents.
  always_ff @(posedge Sysclk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      len_q      <= '0;
      res_data_q <= '0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      len_q      <= len_d;
      res_data_q <= res_data_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end
  end

  // Next-state logic, buffer write control and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    len_d      = len_q;
    res_data_d = res_data_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
    buf_we     = 1'b0;
    buf_waddr  = wr_ptr_q;
    buf_wdata  = bus.Char_In;
    char_ready = 1'b0;
    en         = 1'b0;
    st         = 1'b0;
    res_valid  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        char_ready = 1'b1;
        wr_ptr_d   = '0;
        // The first byte always lands at slot 0, whatever pointer value is left over.
        buf_waddr  = '0;
        if (bus.Char_Valid) begin
          err_d = 1'b0;
          // A bare terminator is an empty expression and is simply discarded.
          if (bus.Char_In != END_CHAR) begin
            buf_we   = 1'b1;
            wr_ptr_d = AW'(1);
            len_d    = '0;
            state_d  = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        char_ready = 1'b1;
        if (bus.Char_Valid) begin
          buf_we = 1'b1;
          if (bus.Char_In == END_CHAR) begin
            len_d   = next_len(wr_ptr_q);
            state_d = ST_KICK;
          end else if (wr_ptr_q == LAST_PTR) begin
            // Buffer full without a terminator: force one into the last slot.
            buf_wdata = END_CHAR;
            len_d     = FULL_LEN;
            err_d     = 1'b1;
            state_d   = ST_KICK;
          end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end
      end

      ST_KICK: begin
        en       = 1'b1;
        st       = 1'b1;
        tmo_d    = '0;
        wr_ptr_d = '0;
        state_d  = ST_RUN;
      end

      ST_RUN: begin
        en = 1'b1;
        // Finish takes priority over an expiring timeout on the same cycle.
        if (bus.Finish) begin
          res_data_d = bus.Result;
          state_d    = ST_RESULT;
        end else if (tmo_q == TMO_LAST) begin
          res_data_d = TIMEOUT_RESULT;
          err_d      = 1'b1;
          state_d    = ST_RESULT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_RESULT: begin
        en        = 1'b1;
        res_valid = 1'b1;
        if (bus.Res_Ready) begin
          state_d = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.Char_Ready = char_ready;
  assign bus.En         = en;
  assign bus.St         = st;
  assign bus.Res_Valid  = res_valid;
  assign bus.Res_Data   = res_data_q;
  assign bus.Err        = err_q;
  assign bus.Instr      = ({1'b0, bus.Instr_Addr} < len_q) ? buf_rdata : END_CHAR;

endmodule
